// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch controller and imem.
// The fetch side issues a request address; memory answers with a ready strobe and data.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues imem requests, fills the IF/ID register,
// parks a response under stall in a skid buffer, and flushes on decode redirect.
//   state | meaning
//   BOOT  | after reset, no request
//   FETCH | request outstanding for imem_addr (== pc)
//   BUF   | response held in skid buffer while decode stalls
//   DRAIN | stale request outstanding after redirect; response is dropped
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    fetch_ctrl_if.master        imem,
    output logic [31:0]         pc_o,
    output logic                ifid_valid_o,
    output logic [31:0]         ifid_pc_o,
    output logic [31:0]         ifid_instr_o
);

    typedef enum logic [1:0] {BOOT, FETCH, BUF, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = {redirect_pc_i[31:2], 2'b00};
    assign pc_inc = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        // Flush is common to every non-BOOT state; ifid_pc is deliberately kept.
        if (redirect_i && state_q != BOOT) begin
            pc_d         = target;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_pc_d    = 32'h0;
            skid_instr_d = 32'h0;
        end

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                addr_d  = pc_q;
            end
            FETCH: begin
                if (redirect_i) begin
                    if (imem.imem_ready) begin
                        addr_d = target;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    if (stall_i) begin
                        skid_pc_d    = addr_q;
                        skid_instr_d = imem.imem_rdata;
                        state_d      = BUF;
                    end else begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = addr_q;
                        ifid_instr_d = imem.imem_rdata;
                        pc_d         = pc_inc;
                        addr_d       = pc_inc;
                    end
                end
            end
            BUF: begin
                if (redirect_i) begin
                    state_d = FETCH;
                    addr_d  = target;
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = skid_pc_q;
                    ifid_instr_d = skid_instr_q;
                    pc_d         = pc_inc;
                    addr_d       = pc_inc;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                if (imem.imem_ready) begin
                    state_d = FETCH;
                    addr_d  = redirect_i ? target : pc_q;
                end
            end
            default: state_d = BOOT;
        endcase

        req_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc_o           = pc_q;
    assign ifid_valid_o   = ifid_valid_q;
    assign ifid_pc_o      = ifid_pc_q;
    assign ifid_instr_o   = ifid_instr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, memory wait, stall/skid, redirects,
// reset mid-request, and pc wraparound on a second instance.
module tb_fetch_ctrl;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] MAGIC = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, ready;
    logic [31:0] redirect_pc;
    logic [31:0] pc, ifid_pc, ifid_instr;
    logic        ifid_valid;

    logic        reset2;
    logic        zero2 = 1'b0;
    logic [31:0] zpc2 = 32'h0;
    logic [31:0] pc2, ifid_pc2, ifid_instr2;
    logic        ifid_valid2;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_ctrl_if bus ();
    fetch_ctrl_if bus2 ();

    assign bus.imem_ready  = ready;
    assign bus.imem_rdata  = bus.imem_addr ^ MAGIC;
    assign bus2.imem_ready = 1'b1;
    assign bus2.imem_rdata = bus2.imem_addr ^ MAGIC;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem         (bus.master),
        .pc_o         (pc),
        .ifid_valid_o (ifid_valid),
        .ifid_pc_o    (ifid_pc),
        .ifid_instr_o (ifid_instr)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk          (clk),
        .reset        (reset2),
        .stall_i      (zero2),
        .redirect_i   (zero2),
        .redirect_pc_i(zpc2),
        .imem         (bus2.master),
        .pc_o         (pc2),
        .ifid_valid_o (ifid_valid2),
        .ifid_pc_o    (ifid_pc2),
        .ifid_instr_o (ifid_instr2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
        chk({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, v});
        chk({tag, ".pc"}, ifid_pc, p);
        chk({tag, ".instr"}, ifid_instr, i);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; ready = 1'b1; redirect_pc = 32'h0;
        reset2 = 1'b1;
        tick(); tick();
        chk("rst.req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst.addr", bus.imem_addr, 32'h0);
        chk("rst.pc", pc, 32'h0);
        chk_ifid("rst", 1'b0, 32'h0, NOP);

        // streaming with memory always ready
        reset = 1'b0;
        tick();
        chk("c1.req", {31'h0, bus.imem_req}, 32'h1);
        chk("c1.addr", bus.imem_addr, 32'h0);
        chk("c1.valid", {31'h0, ifid_valid}, 32'h0);
        tick();
        chk_ifid("c2", 1'b1, 32'h0, 32'h0 ^ MAGIC);
        chk("c2.addr", bus.imem_addr, 32'h4);
        chk("c2.pc", pc, 32'h4);
        tick();
        chk_ifid("c3", 1'b1, 32'h4, 32'h4 ^ MAGIC);
        chk("c3.addr", bus.imem_addr, 32'h8);

        // memory wait at 0x8
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wait.addr", bus.imem_addr, 32'h8);
            chk("wait.req", {31'h0, bus.imem_req}, 32'h1);
            chk("wait.ifid_pc", ifid_pc, 32'h4);
        end
        ready = 1'b1;
        tick();
        chk_ifid("resume", 1'b1, 32'h8, 32'h8 ^ MAGIC);
        chk("resume.addr", bus.imem_addr, 32'hC);

        // stall as response for 0xC arrives -> skid buffer
        stall = 1'b1;
        tick();
        chk("buf.req", {31'h0, bus.imem_req}, 32'h0);
        chk_ifid("buf1", 1'b1, 32'h8, 32'h8 ^ MAGIC);
        tick();
        chk("buf2.req", {31'h0, bus.imem_req}, 32'h0);
        chk_ifid("buf2", 1'b1, 32'h8, 32'h8 ^ MAGIC);
        stall = 1'b0;
        tick();
        chk_ifid("unbuf", 1'b1, 32'hC, 32'hC ^ MAGIC);
        chk("unbuf.addr", bus.imem_addr, 32'h10);
        chk("unbuf.req", {31'h0, bus.imem_req}, 32'h1);

        // redirect to 0x103 while 0x10 outstanding and memory not ready
        ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        chk_ifid("drain", 1'b0, 32'hC, NOP);
        chk("drain.pc", pc, 32'h100);
        chk("drain.addr", bus.imem_addr, 32'h10);
        chk("drain.req", {31'h0, bus.imem_req}, 32'h1);
        redirect = 1'b0;
        tick();
        chk("drain2.addr", bus.imem_addr, 32'h10);
        ready = 1'b1;
        tick();
        chk("drained.addr", bus.imem_addr, 32'h100);
        chk("drained.valid", {31'h0, ifid_valid}, 32'h0);
        tick();
        chk_ifid("tgt", 1'b1, 32'h100, 32'h100 ^ MAGIC);
        chk("tgt.addr", bus.imem_addr, 32'h104);

        // redirect + stall + ready together: flush wins
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h200;
        tick();
        chk_ifid("prio", 1'b0, 32'h100, NOP);
        chk("prio.addr", bus.imem_addr, 32'h200);
        chk("prio.pc", pc, 32'h200);
        chk("prio.req", {31'h0, bus.imem_req}, 32'h1);
        redirect = 1'b0; stall = 1'b0;
        tick();
        chk_ifid("prio2", 1'b1, 32'h200, 32'h200 ^ MAGIC);

        // redirect while response sits in skid buffer
        stall = 1'b1;
        tick();
        chk("buf3.req", {31'h0, bus.imem_req}, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h300;
        tick();
        chk_ifid("bufredir", 1'b0, 32'h200, NOP);
        chk("bufredir.addr", bus.imem_addr, 32'h300);
        chk("bufredir.req", {31'h0, bus.imem_req}, 32'h1);
        redirect = 1'b0; stall = 1'b0;
        tick();
        chk_ifid("bufredir2", 1'b1, 32'h300, 32'h300 ^ MAGIC);

        // reset mid-request overrides redirect/stall; late ready ignored in BOOT
        ready = 1'b0;
        tick();
        chk("pre_rst.addr", bus.imem_addr, 32'h304);
        reset = 1'b1; ready = 1'b1; redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h500;
        tick();
        chk("rst2.req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst2.addr", bus.imem_addr, 32'h0);
        chk("rst2.pc", pc, 32'h0);
        chk_ifid("rst2", 1'b0, 32'h0, NOP);
        reset = 1'b0; redirect = 1'b0; stall = 1'b0;
        tick();
        chk("boot.valid", {31'h0, ifid_valid}, 32'h0);
        chk("boot.req", {31'h0, bus.imem_req}, 32'h1);
        tick();
        chk_ifid("boot2", 1'b1, 32'h0, 32'h0 ^ MAGIC);

        // pc wraparound on second instance
        reset2 = 1'b0;
        tick();
        chk("wrap.addr0", bus2.imem_addr, 32'hFFFF_FFF8);
        tick();
        chk("wrap.pc0", ifid_pc2, 32'hFFFF_FFF8);
        tick();
        chk("wrap.pc1", ifid_pc2, 32'hFFFF_FFFC);
        chk("wrap.next", pc2, 32'h0000_0000);
        tick();
        chk("wrap.pc2", ifid_pc2, 32'h0000_0000);
        chk("wrap.instr2", ifid_instr2, 32'h0 ^ MAGIC);
        chk("wrap.valid", {31'h0, ifid_valid2}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
